// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite response codes and FSM state types for the register-file slave.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Write side: gathering AW and W, then holding a B response.
  typedef enum logic {
    W_COLLECT = 1'b0,
    W_RESP    = 1'b1
  } wr_state_t;

  // Read side: waiting for AR, then holding an R beat.
  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

endpackage

// File: rtl/axi_lite_byte_mem.sv
// Word-organised storage with one byte-strobed write port and one registered read port.
module axi_lite_byte_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int IDX_W      = 8,
  parameter int STRB_W     = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [IDX_W-1:0]      wr_idx_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [STRB_W-1:0]     wr_strb_i,
  input  logic                  rd_en_i,
  input  logic                  rd_hit_i,
  input  logic [IDX_W-1:0]      rd_idx_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Byte-lane write: only lanes with their strobe set are touched.
  // NOTE: the array has no reset so it maps onto RAM; a reset loop would force flops.
  // NOTE: sequential state uses <= so every reader sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb_i[b]) mem_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
  end

  // Read register: captures the addressed word (or zero for a miss) and holds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= rd_hit_i ? mem_q[rd_idx_i] : '0;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axi_lite_regfile_slave.sv
// AXI-Lite slave in front of a byte-strobed word memory; independent AW/W capture,
// range-checked accesses answered with OKAY or SLVERR.
module axi_lite_regfile_slave
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);

  wr_state_t             wr_state_q, wr_state_d;
  rd_state_t             rd_state_q, rd_state_d;
  logic                  aw_full_q, aw_full_d;
  logic                  w_full_q, w_full_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  commit, ar_hs;
  logic                  wr_hit, rd_hit;

  // Range check on the full word index; sub-word address bits are simply dropped.
  assign wr_hit = (awaddr_q >> ADDR_LSB) < DEPTH_A;
  assign rd_hit = (ARADDR >> ADDR_LSB) < DEPTH_A;

  assign AWREADY = !aw_full_q;
  assign WREADY  = !w_full_q;
  assign BVALID  = (wr_state_q == W_RESP);
  assign BRESP   = bresp_q;
  assign ARREADY = (rd_state_q == R_IDLE);
  assign RVALID  = (rd_state_q == R_DATA);
  assign RRESP   = rresp_q;

  // Write path: capture AW/W independently, commit once both are held and B is free.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_full_d  = aw_full_q;
    w_full_d   = w_full_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    commit     = 1'b0;
    if (AWVALID && !aw_full_q) begin
      aw_full_d = 1'b1;
      awaddr_d  = AWADDR;
    end
    if (WVALID && !w_full_q) begin
      w_full_d = 1'b1;
      wdata_d  = WDATA;
      wstrb_d  = WSTRB;
    end
    case (wr_state_q)
      W_COLLECT: begin
        if (aw_full_q && w_full_q) begin
          commit     = 1'b1;
          aw_full_d  = 1'b0;
          w_full_d   = 1'b0;
          bresp_d    = wr_hit ? RESP_OKAY : RESP_SLVERR;
          wr_state_d = W_RESP;
        end
      end
      W_RESP:  if (BREADY) wr_state_d = W_COLLECT;
      default: wr_state_d = W_COLLECT;
    endcase
  end

  // Read path: accept AR while idle, hold the R beat until RREADY.
  always_comb begin
    rd_state_d = rd_state_q;
    rresp_d    = rresp_q;
    ar_hs      = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        if (ARVALID) begin
          ar_hs      = 1'b1;
          rresp_d    = rd_hit ? RESP_OKAY : RESP_SLVERR;
          rd_state_d = R_DATA;
        end
      end
      R_DATA:  if (RREADY) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Write-side state and holding registers; reset discards anything captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= W_COLLECT;
      aw_full_q  <= 1'b0;
      w_full_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      aw_full_q  <= aw_full_d;
      w_full_q   <= w_full_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
    end
  end

  // Read-side state and response code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= R_IDLE;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      rresp_q    <= rresp_d;
    end
  end

  axi_lite_byte_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH),
    .IDX_W     (IDX_W),
    .STRB_W    (STRB_W)
  ) u_mem (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en_i  (commit && wr_hit),
    .wr_idx_i (awaddr_q[ADDR_LSB +: IDX_W]),
    .wr_data_i(wdata_q),
    .wr_strb_i(wstrb_q),
    .rd_en_i  (ar_hs),
    .rd_hit_i (rd_hit),
    .rd_idx_i (ARADDR[ADDR_LSB +: IDX_W]),
    .rd_data_o(RDATA)
  );

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized
// phase, all compared each cycle against a transaction-level model of the slave.
module tb_axi_lite_regfile_slave;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] AWADDR = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b1;
  logic [31:0] ARADDR = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY = 1'b1;

  int checks = 0;
  int errors = 0;

  axi_lite_regfile_slave dut (
    .clk    (clk),     .rst_n  (rst_n),
    .AWADDR (AWADDR),  .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA  (WDATA),   .WSTRB  (WSTRB),   .WVALID (WVALID),  .WREADY(WREADY),
    .BRESP  (BRESP),   .BVALID (BVALID),  .BREADY (BREADY),
    .ARADDR (ARADDR),  .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA  (RDATA),   .RRESP  (RRESP),   .RVALID (RVALID),  .RREADY(RREADY)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t: timed out waiting for handshake", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Slave as seen from the bus: one held AW, one held W, one pending B, one pending R.
  logic [31:0] mdl_mem [DEPTH];
  bit          m_aw, m_w, m_b, m_r;
  logic [31:0] m_awaddr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;

  initial begin
    m_aw = 0; m_w = 0; m_b = 0; m_r = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_aw = 0; m_w = 0; m_b = 0; m_r = 0;
      end else begin
        bit aw_acc, w_acc;
        int unsigned idx;
        check("mon_awready", 32'(AWREADY), 32'(!m_aw));
        check("mon_wready",  32'(WREADY),  32'(!m_w));
        check("mon_bvalid",  32'(BVALID),  32'(m_b));
        check("mon_arready", 32'(ARREADY), 32'(!m_r));
        check("mon_rvalid",  32'(RVALID),  32'(m_r));
        if (m_b) check("mon_bresp", 32'(BRESP), 32'(m_bresp));
        if (m_r) begin
          check("mon_rdata", RDATA, m_rdata);
          check("mon_rresp", 32'(RRESP), 32'(m_rresp));
        end
        aw_acc = AWVALID && !m_aw;
        w_acc  = WVALID && !m_w;
        // Read sees memory as it was before any write landing on this same edge.
        if (m_r) begin
          if (RREADY) m_r = 0;
        end else if (ARVALID) begin
          idx = ARADDR >> 2;
          m_r = 1;
          if (idx < DEPTH) begin m_rdata = mdl_mem[idx]; m_rresp = 2'b00; end
          else begin m_rdata = 32'h0; m_rresp = 2'b10; end
        end
        if (m_b) begin
          if (BREADY) m_b = 0;
        end else if (m_aw && m_w) begin
          idx = m_awaddr >> 2;
          if (idx < DEPTH) begin
            for (int b = 0; b < 4; b++)
              if (m_wstrb[b]) mdl_mem[idx][8*b +: 8] = m_wdata[8*b +: 8];
            m_bresp = 2'b00;
          end else begin
            m_bresp = 2'b10;
          end
          m_b = 1; m_aw = 0; m_w = 0;
        end
        if (aw_acc) begin m_aw = 1; m_awaddr = AWADDR; end
        if (w_acc)  begin m_w = 1; m_wdata = WDATA; m_wstrb = WSTRB; end
      end
    end
  end

  // ---------------- bus driver tasks ----------------
  task automatic send_aw(input logic [31:0] a);
    bit hs = 0;
    AWADDR = a; AWVALID = 1'b1;
    for (int i = 0; i < 100 && !hs; i++) begin
      @(negedge clk); hs = AWREADY;
      @(posedge clk); #1;
    end
    AWVALID = 1'b0;
    if (!hs) timeout_fail("aw_handshake");
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    bit hs = 0;
    WDATA = d; WSTRB = s; WVALID = 1'b1;
    for (int i = 0; i < 100 && !hs; i++) begin
      @(negedge clk); hs = WREADY;
      @(posedge clk); #1;
    end
    WVALID = 1'b0;
    if (!hs) timeout_fail("w_handshake");
  endtask

  task automatic send_ar(input logic [31:0] a);
    bit hs = 0;
    ARADDR = a; ARVALID = 1'b1;
    for (int i = 0; i < 100 && !hs; i++) begin
      @(negedge clk); hs = ARREADY;
      @(posedge clk); #1;
    end
    ARVALID = 1'b0;
    if (!hs) timeout_fail("ar_handshake");
  endtask

  task automatic wait_b(output logic [1:0] resp);
    bit got = 0;
    resp = 2'bxx;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (BVALID && BREADY) begin got = 1; resp = BRESP; end
      @(posedge clk); #1;
    end
    if (!got) timeout_fail("b_handshake");
  endtask

  task automatic wait_r(output logic [31:0] data, output logic [1:0] resp);
    bit got = 0;
    data = 'x; resp = 2'bxx;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (RVALID && RREADY) begin got = 1; data = RDATA; resp = RRESP; end
      @(posedge clk); #1;
    end
    if (!got) timeout_fail("r_handshake");
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int aw_dly, input int w_dly, output logic [1:0] resp);
    fork
      begin repeat (aw_dly) @(posedge clk); if (aw_dly > 0) #1; send_aw(a); end
      begin repeat (w_dly) @(posedge clk); if (w_dly > 0) #1; send_w(d, s); end
    join
    wait_b(resp);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] data, output logic [1:0] resp);
    send_ar(a);
    wait_r(data, resp);
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 15) == 0) return $urandom;
    return (32'($urandom_range(0, 279)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  resp, resp2;
    logic [31:0] data;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_awready", 32'(AWREADY), 32'd1);
    check("rst_wready",  32'(WREADY),  32'd1);
    check("rst_arready", 32'(ARREADY), 32'd1);
    check("rst_bvalid",  32'(BVALID),  32'd0);
    check("rst_rvalid",  32'(RVALID),  32'd0);
    check("rst_bresp",   32'(BRESP),   32'd0);
    check("rst_rresp",   32'(RRESP),   32'd0);
    check("rst_rdata",   RDATA,        32'd0);
    @(posedge clk); #1;

    // Give every word a defined value so later reads are fully predictable.
    for (int i = 0; i < DEPTH; i++) wr(32'(i * 4), $urandom, 4'hF, 0, 0, resp);

    // 1: AW first, W three cycles later.
    wr(32'h10, 32'hDEADBEEF, 4'hF, 0, 3, resp);
    check("s1_bresp", 32'(resp), 32'd0);
    rd(32'h10, data, resp);
    check("s1_rdata", data, 32'hDEADBEEF);
    check("s1_rresp", 32'(resp), 32'd0);

    // 2: W first, partial strobes.
    wr(32'h10, 32'h11223344, 4'b0101, 3, 0, resp);
    check("s2_bresp", 32'(resp), 32'd0);
    rd(32'h10, data, resp);
    check("s2_rdata", data, 32'hDE22BE44);
    rd(32'h13, data, resp);
    check("s2_unaligned_rdata", data, 32'hDE22BE44);

    // 3: out-of-range write and read.
    wr(32'h0, 32'h01234567, 4'hF, 0, 0, resp);
    wr(32'h400, 32'hFFFFFFFF, 4'hF, 0, 0, resp);
    check("s3_bresp", 32'(resp), 32'd2);
    rd(32'h400, data, resp);
    check("s3_rdata", data, 32'd0);
    check("s3_rresp", 32'(resp), 32'd2);
    rd(32'h0, data, resp);
    check("s3_word0", data, 32'h01234567);

    // 4: B back-pressure with a second write queued behind it.
    BREADY = 1'b0;
    fork send_aw(32'h30); send_w(32'hA5A5A5A5, 4'hF); join
    fork send_aw(32'h34); send_w(32'h5A5A5A5A, 4'hF); join
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("s4_bvalid",  32'(BVALID),  32'd1);
      check("s4_bresp",   32'(BRESP),   32'd0);
      check("s4_awready", 32'(AWREADY), 32'd0);
      check("s4_wready",  32'(WREADY),  32'd0);
    end
    @(posedge clk); #1;
    BREADY = 1'b1;
    wait_b(resp);
    wait_b(resp2);
    check("s4_bresp1", 32'(resp), 32'd0);
    check("s4_bresp2", 32'(resp2), 32'd0);
    rd(32'h30, data, resp);
    check("s4_rd30", data, 32'hA5A5A5A5);
    rd(32'h34, data, resp);
    check("s4_rd34", data, 32'h5A5A5A5A);

    // 5: R back-pressure, then a read colliding with a write commit.
    RREADY = 1'b0;
    send_ar(32'h10);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("s5_rvalid",  32'(RVALID),  32'd1);
      check("s5_rdata",   RDATA,        32'hDE22BE44);
      check("s5_arready", 32'(ARREADY), 32'd0);
    end
    @(posedge clk); #1;
    RREADY = 1'b1;
    wait_r(data, resp);
    check("s5_rdata_hs", data, 32'hDE22BE44);
    wr(32'h14, 32'hCAFEF00D, 4'hF, 0, 0, resp);
    AWADDR = 32'h14; AWVALID = 1'b1; WDATA = 32'h0BADC0DE; WSTRB = 4'hF; WVALID = 1'b1;
    @(posedge clk); #1;
    AWVALID = 1'b0; WVALID = 1'b0; ARADDR = 32'h14; ARVALID = 1'b1;
    @(posedge clk); #1;
    ARVALID = 1'b0;
    fork wait_r(data, resp); wait_b(resp2); join
    check("s5_same_edge_old", data, 32'hCAFEF00D);
    rd(32'h14, data, resp);
    check("s5_after_write", data, 32'h0BADC0DE);

    // 6: reset with a pending B and a captured AW/W.
    BREADY = 1'b0;
    fork send_aw(32'h20); send_w(32'h600DF00D, 4'hF); join
    fork send_aw(32'h20); send_w(32'hBAD0BAD0, 4'hF); join
    @(negedge clk);
    check("s6_pre_bvalid",  32'(BVALID),  32'd1);
    check("s6_pre_awready", 32'(AWREADY), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("s6_rst_bvalid",  32'(BVALID),  32'd0);
    check("s6_rst_awready", 32'(AWREADY), 32'd1);
    check("s6_rst_wready",  32'(WREADY),  32'd1);
    check("s6_rst_rdata",   RDATA,        32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    BREADY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("s6_no_stale_b", 32'(BVALID), 32'd0);
    end
    @(posedge clk); #1;
    rd(32'h20, data, resp);
    check("s6_mem_kept", data, 32'h600DF00D);

    // Randomized traffic; the model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      bit aw_hs, w_hs, ar_hs;
      @(negedge clk);
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      ar_hs = ARVALID && ARREADY;
      @(posedge clk); #1;
      if (!AWVALID || aw_hs) begin AWVALID = 1'($urandom_range(0, 1)); AWADDR = rand_addr(); end
      if (!WVALID || w_hs) begin
        WVALID = 1'($urandom_range(0, 1)); WDATA = $urandom; WSTRB = 4'($urandom_range(0, 15));
      end
      if (!ARVALID || ar_hs) begin ARVALID = 1'($urandom_range(0, 1)); ARADDR = rand_addr(); end
      BREADY = ($urandom_range(0, 3) != 0);
      RREADY = ($urandom_range(0, 3) != 0);
    end
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0; BREADY = 1'b1; RREADY = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
